// File: rtl/fma16_resp_if.sv
// Request/response bundle for fma16_resp. Optional checker signals exist only
// when FMA16_RESP_CHECK_EN is defined.
interface fma16_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_x;
  logic [15:0] req_y;
  logic [15:0] req_z;
  logic [7:0]  req_ctrl;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
`ifdef FMA16_RESP_CHECK_EN
  logic [15:0] req_rexp;
  logic [3:0]  req_fexp;
  logic        rsp_mismatch;

  modport master (output req_valid, req_x, req_y, req_z, req_ctrl, req_rexp, req_fexp, rsp_ready,
                  input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_mismatch);
  modport slave  (input  req_valid, req_x, req_y, req_z, req_ctrl, req_rexp, req_fexp, rsp_ready,
                  output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_mismatch);
`else
  modport master (output req_valid, req_x, req_y, req_z, req_ctrl, rsp_ready,
                  input  req_ready, rsp_valid, rsp_result, rsp_flags);
  modport slave  (input  req_valid, req_x, req_y, req_z, req_ctrl, rsp_ready,
                  output req_ready, rsp_valid, rsp_result, rsp_flags);
`endif
endinterface

// File: rtl/fma16_resp.sv
// Valid/ready front end around a combinational binary16 FMA with an output FIFO.
// Define FMA16_RESP_CHECK_EN to add the expected-value checker and err_count.
module fma16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic        mul,
  input  logic        add,
  input  logic        negp,
  input  logic        negz,
  input  logic [1:0]  roundmode,  // 00 rz, 01 rne, 10 rm, 11 rp
  output logic [15:0] result,
  output logic [3:0]  flags       // {invalid, overflow, underflow, inexact}
);
  logic [15:0] ye, ze;
  logic [4:0]  ex, ey, ez;
  logic [10:0] mx, my, mz;
  logic        x_nan, y_nan, z_nan, any_snan, x_inf, y_inf, z_inf, x_zero, y_zero;
  logic        sp, sz, sign, zsign, rup, inexact, to_inf;
  logic [83:0] pm, zm, mag, rem, half;
  logic [6:0]  p, lsb;
  logic [11:0] q;
  logic [16:0] bits;

  assign ye = mul ? y : 16'h3C00;
  assign ze = add ? z : 16'h0000;

  // Exact sum is formed as an integer scaled by 2^-48, then rounded once.
  always_comb begin
    x_nan    = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
    y_nan    = (ye[14:10] == 5'h1F) && (ye[9:0] != 10'd0);
    z_nan    = (ze[14:10] == 5'h1F) && (ze[9:0] != 10'd0);
    any_snan = (x_nan && !x[9]) || (y_nan && !ye[9]) || (z_nan && !ze[9]);
    x_inf    = (x[14:10] == 5'h1F) && (x[9:0] == 10'd0);
    y_inf    = (ye[14:10] == 5'h1F) && (ye[9:0] == 10'd0);
    z_inf    = (ze[14:10] == 5'h1F) && (ze[9:0] == 10'd0);
    x_zero   = (x[14:0] == 15'd0);
    y_zero   = (ye[14:0] == 15'd0);
    sp       = x[15] ^ ye[15] ^ negp;
    sz       = ze[15] ^ negz;
    ex       = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
    ey       = (ye[14:10] == 5'd0) ? 5'd1 : ye[14:10];
    ez       = (ze[14:10] == 5'd0) ? 5'd1 : ze[14:10];
    mx       = {x[14:10] != 5'd0, x[9:0]};
    my       = {ye[14:10] != 5'd0, ye[9:0]};
    mz       = {ze[14:10] != 5'd0, ze[9:0]};
    pm       = (84'(mx) * 84'(my)) << (6'(ex) + 6'(ey) - 6'd2);
    zm       = 84'(mz) << (6'(ez) + 6'd23);
    if (sp == sz) begin
      mag = pm + zm;
      sign = sp;
    end else if (pm >= zm) begin
      mag = pm - zm;
      sign = sp;
    end else begin
      mag = zm - pm;
      sign = sz;
    end
    zsign = add ? ((sp == sz) ? sp : (roundmode == 2'b10)) : sp;
    p = 7'd0;
    for (int i = 0; i < 84; i++) begin
      if (mag[i]) p = 7'(i);
    end
    lsb     = (p >= 7'd34) ? p - 7'd10 : 7'd24;
    q       = 12'(mag >> lsb);
    rem     = mag & ((84'd1 << lsb) - 84'd1);
    half    = 84'd1 << (lsb - 7'd1);
    inexact = (rem != 84'd0);
    case (roundmode)
      2'b01:   rup = (rem > half) || ((rem == half) && q[0]);
      2'b10:   rup = sign && inexact;
      2'b11:   rup = !sign && inexact;
      default: rup = 1'b0;
    endcase
    // Mantissa carry propagates straight into the exponent field.
    bits   = {lsb - 7'd24, 10'd0} + 17'(q) + 17'(rup);
    to_inf = (roundmode == 2'b01) || ((roundmode == 2'b10) && sign) || ((roundmode == 2'b11) && !sign);

    result = 16'h7E00;
    flags  = 4'b0000;
    if (x_nan || y_nan || z_nan) begin
      flags[3] = any_snan;
    end else if ((x_inf && y_zero) || (x_zero && y_inf) || ((x_inf || y_inf) && z_inf && (sp != sz))) begin
      flags[3] = 1'b1;
    end else if (x_inf || y_inf) begin
      result = {sp, 15'h7C00};
    end else if (z_inf) begin
      result = {sz, 15'h7C00};
    end else if (mag == 84'd0) begin
      result = {zsign, 15'h0000};
    end else if (bits >= 17'h07C00) begin
      result = {sign, to_inf ? 15'h7C00 : 15'h7BFF};
      flags  = 4'b0101;
    end else begin
      result = {sign, bits[14:0]};
      flags  = {2'b00, inexact && (bits < 17'h00400), inexact};
    end
  end
endmodule

module fma16_resp #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
`ifdef FMA16_RESP_CHECK_EN
  output logic [31:0]  err_count,
`endif
  output logic [31:0]  op_count,
  fma16_resp_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  logic          s1_valid_reg;
  logic [15:0]   s1_x_reg, s1_y_reg, s1_z_reg;
  logic [5:0]    s1_ctrl_reg;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   fifo_count_reg, fifo_count_next;
  logic [31:0]   op_count_reg;
  logic [15:0]   res_mem_reg [DEPTH];
  logic [3:0]    flg_mem_reg [DEPTH];
  logic [15:0]   fma_result;
  logic [3:0]    fma_flags;
  logic          accept, push, pop, unused_ctrl;

  assign unused_ctrl   = ^bus.req_ctrl[7:6];
  assign bus.req_ready = (int'(fifo_count_reg) + int'(s1_valid_reg)) < DEPTH;
  assign bus.rsp_valid = (fifo_count_reg != '0);
  assign accept        = bus.req_valid && bus.req_ready;
  assign push          = s1_valid_reg;
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign op_count      = op_count_reg;

  fma16 u_fma16 (
    .x(s1_x_reg), .y(s1_y_reg), .z(s1_z_reg),
    .mul(s1_ctrl_reg[3]), .add(s1_ctrl_reg[2]), .negp(s1_ctrl_reg[1]), .negz(s1_ctrl_reg[0]),
    .roundmode(s1_ctrl_reg[5:4]), .result(fma_result), .flags(fma_flags)
  );

  always_comb begin
    fifo_count_next = fifo_count_reg;
    case ({push, pop})
      2'b10:   fifo_count_next = fifo_count_reg + 1'b1;
      2'b01:   fifo_count_next = fifo_count_reg - 1'b1;
      default: fifo_count_next = fifo_count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg   <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
      op_count_reg   <= '0;
    end else begin
      s1_valid_reg   <= accept;
      fifo_count_reg <= fifo_count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (accept) op_count_reg <= op_count_reg + 32'd1;
    end
  end

  // Datapath registers carry no reset; s1_valid and the FIFO count qualify them.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_x_reg    <= bus.req_x;
      s1_y_reg    <= bus.req_y;
      s1_z_reg    <= bus.req_z;
      s1_ctrl_reg <= bus.req_ctrl[5:0];
    end
    if (push) begin
      res_mem_reg[wr_ptr_reg] <= fma_result;
      flg_mem_reg[wr_ptr_reg] <= fma_flags;
    end
  end

  assign bus.rsp_result = res_mem_reg[rd_ptr_reg];
  assign bus.rsp_flags  = flg_mem_reg[rd_ptr_reg];

`ifdef FMA16_RESP_CHECK_EN
  logic [15:0] s1_rexp_reg;
  logic [3:0]  s1_fexp_reg;
  logic        mis_mem_reg [DEPTH];
  logic [31:0] err_count_reg;

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_rexp_reg <= bus.req_rexp;
      s1_fexp_reg <= bus.req_fexp;
    end
    if (push) mis_mem_reg[wr_ptr_reg] <= (fma_result != s1_rexp_reg) || (fma_flags != s1_fexp_reg);
  end

  always_ff @(posedge clk) begin
    if (reset) err_count_reg <= '0;
    else if (pop && mis_mem_reg[rd_ptr_reg] && (err_count_reg != 32'hFFFF_FFFF))
      err_count_reg <= err_count_reg + 32'd1;
  end

  assign bus.rsp_mismatch = mis_mem_reg[rd_ptr_reg];
  assign err_count        = err_count_reg;
`endif
endmodule

// File: tb/tb_fma16_resp.sv
// Directed bench for fma16_resp: arithmetic vectors, latency, backpressure,
// reset mid-stream and (with FMA16_RESP_CHECK_EN) the in-line checker.
module tb_fma16_resp;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] op_count;
`ifdef FMA16_RESP_CHECK_EN
  logic [31:0] err_count;
`endif
  int tests = 0;
  int fails = 0;
  int exp_ops = 0;

  fma16_resp_if bus();

  fma16_resp #(.DEPTH(4)) dut (
    .clk(clk),
    .reset(reset),
`ifdef FMA16_RESP_CHECK_EN
    .err_count(err_count),
`endif
    .op_count(op_count),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic drive_req(input logic [15:0] x, y, z, input logic [7:0] ctrl);
    bus.req_valid = 1'b1;
    bus.req_x = x;
    bus.req_y = y;
    bus.req_z = z;
    bus.req_ctrl = ctrl;
  endtask

  // Sends one request with rsp_ready=1 and captures the response head.
  task automatic do_single(input logic [15:0] x, y, z, input logic [7:0] ctrl,
                           output logic [15:0] r, output logic [3:0] f, output int lat);
    int waitc;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    drive_req(x, y, z, ctrl);
    waitc = 0;
    while (!bus.req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    @(posedge clk);
    exp_ops++;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    r = bus.rsp_result;
    f = bus.rsp_flags;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_ops = 0;
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
    tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    tests++; if (op_count !== 32'd0) begin fails++; $display("FAIL reset_op_count: got %0d expected 0", op_count); end
`ifdef FMA16_RESP_CHECK_EN
    tests++; if (err_count !== 32'd0) begin fails++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
`endif
    $display("[TB] reset done");
  endtask

  task automatic test_vector(input string name, input logic [15:0] x, y, z, input logic [7:0] ctrl,
                             input logic [15:0] er, input logic [3:0] ef);
    logic [15:0] r;
    logic [3:0]  f;
    int lat;
    do_single(x, y, z, ctrl, r, f, lat);
    $display("[TB] %s: x=%h y=%h z=%h ctrl=%h -> %h/%b lat=%0d", name, x, y, z, ctrl, r, f, lat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL %s_latency: got %0d expected 2", name, lat); end
    tests++; if (r !== er) begin fails++; $display("FAIL %s_result: got %h expected %h", name, r, er); end
    tests++; if (f !== ef) begin fails++; $display("FAIL %s_flags: got %b expected %b", name, f, ef); end
    tests++; if (op_count !== 32'(exp_ops)) begin fails++; $display("FAIL %s_op_count: got %0d expected %0d", name, op_count, exp_ops); end
  endtask

  task automatic test_arith;
    test_vector("mul",     16'h3C00, 16'h3C00, 16'h0000, 8'h08, 16'h3C00, 4'b0000);
    test_vector("fma",     16'h3C00, 16'h4000, 16'h3C00, 8'h0C, 16'h4200, 4'b0000);
    test_vector("invalid", 16'h7C00, 16'h0000, 16'h0000, 8'h08, 16'h7E00, 4'b1000);
    test_vector("rz_inex", 16'h3C01, 16'h3C01, 16'h0000, 8'h08, 16'h3C02, 4'b0001);
    test_vector("rp_inex", 16'h3C01, 16'h3C01, 16'h0000, 8'h38, 16'h3C03, 4'b0001);
    test_vector("ovf_rne", 16'h7BFF, 16'h4000, 16'h0000, 8'h18, 16'h7C00, 4'b0101);
    test_vector("ovf_rz",  16'h7BFF, 16'h4000, 16'h0000, 8'h08, 16'h7BFF, 4'b0101);
  endtask

  task automatic test_back_to_back;
    logic [15:0] xs [4] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400};
    logic [15:0] ex [4] = '{16'h4000, 16'h4400, 16'h4600, 16'h4800};
    logic [15:0] got [4];
    int k = 0, n = 0, drive_cycles = 0;
    bit acc;
    for (int c = 0; c < 30 && (k < 4 || n < 4); c++) begin
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      if (bus.rsp_valid && n < 4) begin got[n] = bus.rsp_result; n++; end
      if (k < 4) begin drive_req(xs[k], 16'h4000, 16'h0000, 8'h08); drive_cycles++; end
      else bus.req_valid = 1'b0;
      acc = bus.req_ready && (k < 4);
      @(posedge clk);
      if (acc) begin k++; exp_ops++; end
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    $display("[TB] back_to_back: accepted %0d in %0d cycles, %0d responses", k, drive_cycles, n);
    tests++; if (drive_cycles !== 4) begin fails++; $display("FAIL b2b_throughput: got %0d cycles expected 4", drive_cycles); end
    tests++; if (n !== 4) begin fails++; $display("FAIL b2b_count: got %0d expected 4", n); end
    for (int i = 0; i < n; i++) begin
      tests++; if (got[i] !== ex[i]) begin fails++; $display("FAIL b2b_result%0d: got %h expected %h", i, got[i], ex[i]); end
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] xs [6] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600};
    logic [15:0] got [6];
    int k = 0, n = 0;
    bit acc;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive_req(xs[k < 6 ? k : 5], 16'h3C00, 16'h0000, 8'h08);
      acc = bus.req_ready;
      @(posedge clk);
      if (acc) begin k++; exp_ops++; end
    end
    @(negedge clk);
    $display("[TB] backpressure: accepted %0d with rsp_ready low", k);
    tests++; if (k !== 4) begin fails++; $display("FAIL bp_accepted: got %0d expected 4", k); end
    tests++; if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL bp_req_ready: got %b expected 0", bus.req_ready); end
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 40 && n < 6; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) begin
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL bp_recovery: got %b expected 1", bus.req_ready); end
      end
      if (bus.rsp_valid) begin got[n] = bus.rsp_result; n++; end
      if (k < 6) drive_req(xs[k], 16'h3C00, 16'h0000, 8'h08);
      else bus.req_valid = 1'b0;
      acc = bus.req_ready && (k < 6);
      @(posedge clk);
      if (acc) begin k++; exp_ops++; end
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    tests++; if (n !== 6) begin fails++; $display("FAIL bp_count: got %0d expected 6", n); end
    for (int i = 0; i < n; i++) begin
      $display("[TB] backpressure response %0d: %h", i, got[i]);
      tests++; if (got[i] !== xs[i]) begin fails++; $display("FAIL bp_order%0d: got %h expected %h", i, got[i], xs[i]); end
    end
    tests++; if (op_count !== 32'(exp_ops)) begin fails++; $display("FAIL bp_op_count: got %0d expected %0d", op_count, exp_ops); end
  endtask

  task automatic test_reset_midstream;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_req(16'h4000, 16'h3C00, 16'h0000, 8'h08);
      @(posedge clk);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++; if (bus.rsp_valid !== 1'b1) begin fails++; $display("FAIL mid_queued: got %b expected 1", bus.rsp_valid); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_ops = 0;
    $display("[TB] reset mid-stream applied");
    tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_rsp_valid: got %b expected 0", bus.rsp_valid); end
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL mid_req_ready: got %b expected 1", bus.req_ready); end
    tests++; if (op_count !== 32'd0) begin fails++; $display("FAIL mid_op_count: got %0d expected 0", op_count); end
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_stale%0d: got %b expected 0", c, bus.rsp_valid); end
    end
  endtask

`ifdef FMA16_RESP_CHECK_EN
  task automatic test_checker;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    drive_req(16'h3C00, 16'h3C00, 16'h0000, 8'h08);
    bus.req_rexp = 16'h3C01;
    bus.req_fexp = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    drive_req(16'h3C00, 16'h4000, 16'h3C00, 8'h0C);
    bus.req_rexp = 16'h4200;
    bus.req_fexp = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    $display("[TB] checker head0 result=%h mismatch=%b", bus.rsp_result, bus.rsp_mismatch);
    tests++; if (bus.rsp_mismatch !== 1'b1) begin fails++; $display("FAIL chk_mis0: got %b expected 1", bus.rsp_mismatch); end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    $display("[TB] checker head1 result=%h mismatch=%b", bus.rsp_result, bus.rsp_mismatch);
    tests++; if (bus.rsp_mismatch !== 1'b0) begin fails++; $display("FAIL chk_mis1: got %b expected 0", bus.rsp_mismatch); end
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    tests++; if (err_count !== 32'd1) begin fails++; $display("FAIL chk_err_count: got %0d expected 1", err_count); end
    tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL chk_drained: got %b expected 0", bus.rsp_valid); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.req_z = '0;
    bus.req_ctrl = '0;
    bus.rsp_ready = 1'b0;
`ifdef FMA16_RESP_CHECK_EN
    bus.req_rexp = '0;
    bus.req_fexp = '0;
`endif
    test_reset;
    test_arith;
    test_back_to_back;
    test_backpressure;
    test_reset_midstream;
`ifdef FMA16_RESP_CHECK_EN
    test_checker;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fma16_resp.md
# fma16_resp

Synthesizable request/response front end for the `fma16` half-precision fused multiply-add datapath. It accepts operand packets on a valid/ready request channel, registers them, evaluates them through one combinational `fma16` instance, and queues result and flags in an output FIFO drained on a valid/ready response channel. The request fields mirror the 16-bit fma test-vector layout, so the block can replay vector streams on silicon or FPGA. An optional in-line checker compares against expected values and counts errors.

## Interface

- `DEPTH`, default 4: output FIFO entries; power of 2, ≥ 2.
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request packet valid.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_x`, `req_y`, `req_z`  in  16 each  binary16 operands.
- `req_ctrl`  in  8  control field, decoded as follows:
  - `[5:4]` roundmode
  - `[3]` mul
  - `[2]` add
  - `[1]` negp
  - `[0]` negz
  - `[7:6]` ignored.
- `rsp_valid`  out  1  FIFO head holds a response.
- `rsp_ready`  in  1  consumer takes the head this cycle.
- `rsp_result`  out  16  FIFO head result.
- `rsp_flags`  out  4  FIFO head flags {invalid, overflow, underflow, inexact}.
- `op_count`  out  32  number of accepted requests.
- Checker ports, present only with `FMA16_RESP_CHECK_EN`:
  - `req_rexp`  in  16  expected result.
  - `req_fexp`  in  4  expected flags.
  - `rsp_mismatch`  out  1  head mismatch bit.
  - `err_count`  out  32  mismatches popped.

## Operation

- Request handshake: a request is accepted when `req_valid & req_ready` at a rising edge.
- Stage S1: a register holding x, y, z, ctrl and `s1_valid`. It loads on accept. It clears when its result is pushed and no new accept occurs in the same cycle.
- Evaluation: `fma16` is driven combinationally from S1.
- FIFO push: when `s1_valid` is set, result and flags are pushed into the FIFO at the next edge.
- Credit rule: `req_ready = (fifo_count + s1_valid) < DEPTH`.
  - `req_ready` is computed from registers only.
  - It never depends on `rsp_ready` or `req_valid`.
  - Because of this rule, a push never finds the FIFO full.
- Response handshake: a pop occurs when `rsp_valid & rsp_ready` at an edge. `rsp_valid = (fifo_count != 0)`. The `rsp_*` outputs show the head entry directly.
- Pointers: write and read pointers are `log2(DEPTH)` bits and wrap modulo DEPTH. `fifo_count` is `log2(DEPTH)+1` bits.
- Simultaneous push and pop: `fifo_count` is unchanged and both pointers advance.
- Pop on empty: not possible, since `rsp_valid` is 0.
- `op_count` increments by 1 per accept and wraps at 2^32.
- Ordering: responses leave in strict acceptance order; nothing is dropped or reordered.
- Reset asserted on any edge:
  - clears `s1_valid`, both pointers, `fifo_count`, `op_count` and `err_count`;
  - discards all in-flight work;
  - takes priority over a simultaneous accept or pop.

## Timing

- Reset values: `req_ready`=1, `rsp_valid`=0, `op_count`=0, `err_count`=0. `rsp_result`, `rsp_flags` and `rsp_mismatch` are don't-care while `rsp_valid`=0.
- Latency: a request accepted at edge N is pushed at edge N+1 and shows `rsp_valid`=1 after N+1. Minimum latency is 2 edges.
- Throughput: one request per cycle sustained while `rsp_ready`=1.
- Backpressure: with `rsp_ready` held low, exactly DEPTH requests are accepted, then `req_ready`=0.
- Recovery: the first pop re-raises `req_ready` in the following cycle.

## Configuration

- `FMA16_RESP_CHECK_EN`, when defined:
  - `req_rexp` and `req_fexp` are captured in S1 and stored in the FIFO.
  - `rsp_mismatch` = (result ≠ rexp) | (flags ≠ fexp), computed at push.
  - `err_count` increments on every pop whose `rsp_mismatch` is 1. It saturates at 2^32−1.
- When undefined: the checker ports, the storage for them and `err_count` do not exist. All other behaviour is identical.

## Test plan

- Multiply only: x=3C00, y=3C00, z=0000, ctrl=08, rsp_ready=1 → result 3C00, flags 0000 two edges after accept. `op_count`=1.
- FMA: x=3C00, y=4000, z=3C00, ctrl=0C → result 4200, flags 0000.
- Invalid: x=7C00, y=0000, z=0000, ctrl=08 → result 7E00, flags 1000.
- Backpressure, DEPTH=4: `rsp_ready`=0, `req_valid` held for 6 requests (1.0, 2.0, 3.0, 4.0, 5.0, 6.0 each ×1.0, ctrl=08).
  - Exactly 4 are accepted and `req_ready` falls.
  - Raise `rsp_ready` → results 3C00, 4000, 4200, 4400 in order, then the remaining 2 (4500, 4600).
- Reset mid-stream: assert `reset` for 1 cycle with 3 results queued → `rsp_valid`=0, `req_ready`=1 and `op_count`=0 on the next cycle. No stale response ever appears.
- Checker (macro defined): send 3C00×3C00+0 with rexp=3C01 and fexp=0000, then a correct vector → `rsp_mismatch` is 1 then 0, and `err_count` ends at 1.
